// File: rtl/me_pkg.sv
// Shared types and width helpers for the integer motion-estimation SAD path.
// Widths scale with the macroblock edge; the DEF_* values are the default build.
package me_pkg;

    localparam int DEF_MACRO_DIM = 16;
    localparam int DEF_MV_W      = 7;
    localparam int DEF_CNT_W     = 12;

    localparam int COL_W = 8 + $clog2(DEF_MACRO_DIM);
    localparam int SAD_W = 8 + $clog2(DEF_MACRO_DIM * DEF_MACRO_DIM);

    function automatic int col_w_of(input int macro_dim);
        return 8 + $clog2(macro_dim);
    endfunction

    function automatic int sad_w_of(input int macro_dim);
        return 8 + $clog2(macro_dim * macro_dim);
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } tracker_state_t;

    typedef struct packed {
        logic                       valid;
        logic                       first;
        logic                       last;
        logic signed [DEF_MV_W-1:0] mv_x;
        logic signed [DEF_MV_W-1:0] mv_y;
    } cand_tag_t;

endpackage

// File: rtl/ad_col_sum.sv
// Registered sum of one pe_col column's absolute-difference bytes.
// The result width holds MACRO_DIM * 255 without overflow.
module ad_col_sum
    import me_pkg::*;
#(
    parameter int MACRO_DIM = DEF_MACRO_DIM,
    parameter int COL_W     = col_w_of(MACRO_DIM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MACRO_DIM*8-1:0] ad,
    output logic [COL_W-1:0]       col_sum
);

    logic [COL_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < MACRO_DIM; i++) begin
            acc = acc + COL_W'(ad[8*i +: 8]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_sum <= '0;
        end else begin
            col_sum <= acc;
        end
    end

endmodule

// File: rtl/sad_min_tracker.sv
// Sums per-PE absolute differences into a candidate SAD (two pipeline stages) and
// tracks the minimum SAD and its motion vector across a search framed by first/last.
module sad_min_tracker
    import me_pkg::*;
#(
    parameter int MACRO_DIM = DEF_MACRO_DIM,
    parameter int MV_W      = DEF_MV_W,
    parameter int CNT_W     = DEF_CNT_W,
    localparam int COLSUM_W = col_w_of(MACRO_DIM),
    localparam int SADSUM_W = sad_w_of(MACRO_DIM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cand_valid,
    input  logic                           cand_first,
    input  logic                           cand_last,
    input  logic signed [MV_W-1:0]         mv_x_in,
    input  logic signed [MV_W-1:0]         mv_y_in,
    input  logic [MACRO_DIM*MACRO_DIM*8-1:0] ad_in,
    output logic                           done,
    output logic [SADSUM_W-1:0]            sad_min,
    output logic signed [MV_W-1:0]         mv_x_best,
    output logic signed [MV_W-1:0]         mv_y_best,
    output logic [CNT_W-1:0]               cand_cnt,
    output logic                           seq_err,
    output tracker_state_t                 state_dbg
);

    // Handshake: cand_valid alone qualifies ad_in, the MV and the first/last tags in
    // the cycle it is high; there is no ready, so one candidate may arrive every cycle.

    cand_tag_t             in_tag, s1_tag, s2_tag;
    logic [COLSUM_W-1:0]   col_sum [MACRO_DIM];
    logic [SADSUM_W-1:0]   sad_sum, s2_sad;

    assign in_tag = '{valid: cand_valid, first: cand_first, last: cand_last,
                      mv_x: mv_x_in, mv_y: mv_y_in};

    // S1: one registered column adder per pe_col column.
    for (genvar c = 0; c < MACRO_DIM; c++) begin : g_col
        ad_col_sum #(
            .MACRO_DIM (MACRO_DIM),
            .COL_W     (COLSUM_W)
        ) u_col (
            .clk     (clk),
            .rst     (rst),
            .ad      (ad_in[MACRO_DIM*8*c +: MACRO_DIM*8]),
            .col_sum (col_sum[c])
        );
    end

    always_comb begin
        sad_sum = '0;
        for (int c = 0; c < MACRO_DIM; c++) begin
            sad_sum = sad_sum + SADSUM_W'(col_sum[c]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_tag <= '0;
            s2_tag <= '0;
            s2_sad <= '0;
        end else begin
            s1_tag <= in_tag;
            s2_tag <= s1_tag;
            s2_sad <= sad_sum;
        end
    end

    // S3: tracker FSM over the in-progress search registers.
    tracker_state_t         state, state_n;
    logic [SADSUM_W-1:0]    min_q, min_n;
    logic signed [MV_W-1:0] bx_q, bx_n, by_q, by_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    logic                   done_n, err_n;

    always_comb begin
        state_n = state;
        min_n   = min_q;
        bx_n    = bx_q;
        by_n    = by_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (s2_tag.valid) begin
            if (s2_tag.first) begin
                // A first inside a search abandons the partial result.
                err_n   = (state == SEARCH);
                min_n   = s2_sad;
                bx_n    = s2_tag.mv_x;
                by_n    = s2_tag.mv_y;
                cnt_n   = CNT_W'(1);
                done_n  = s2_tag.last;
                state_n = s2_tag.last ? IDLE : SEARCH;
            end else if (state == IDLE) begin
                err_n = 1'b1;
            end else begin
                cnt_n = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                if (s2_sad < min_q) begin
                    min_n = s2_sad;
                    bx_n  = s2_tag.mv_x;
                    by_n  = s2_tag.mv_y;
                end
                if (s2_tag.last) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            min_q     <= '1;
            bx_q      <= '0;
            by_q      <= '0;
            cnt_q     <= '0;
            done      <= 1'b0;
            seq_err   <= 1'b0;
            sad_min   <= '1;
            mv_x_best <= '0;
            mv_y_best <= '0;
            cand_cnt  <= '0;
        end else begin
            state   <= state_n;
            min_q   <= min_n;
            bx_q    <= bx_n;
            by_q    <= by_n;
            cnt_q   <= cnt_n;
            done    <= done_n;
            seq_err <= err_n;
            if (done_n) begin
                sad_min   <= min_n;
                mv_x_best <= bx_n;
                mv_y_best <= by_n;
                cand_cnt  <= cnt_n;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Self-checking bench for sad_min_tracker: table-driven candidates plus hand-written
// sequences; expected done/seq_err events are queued at drive time and matched at output.
module tb_sad_min_tracker;
  import me_pkg::*;

  localparam int MD    = 16;
  localparam int NPE   = MD * MD;
  localparam int MV_W  = 7;
  localparam int CNT_W = 12;
  localparam int SW    = 16;
  localparam int EXP_W = 32 + SW + 2 * MV_W + CNT_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             cand_valid, cand_first, cand_last;
  logic [MV_W-1:0]  mv_x_in, mv_y_in;
  logic [NPE*8-1:0] ad_in;
  logic             done, seq_err;
  logic [SW-1:0]    sad_min;
  logic [MV_W-1:0]  mv_x_best, mv_y_best;
  logic [CNT_W-1:0] cand_cnt;
  tracker_state_t   state_dbg;

  sad_min_tracker #(.MACRO_DIM(MD), .MV_W(MV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cand_valid(cand_valid), .cand_first(cand_first), .cand_last(cand_last),
    .mv_x_in(mv_x_in), .mv_y_in(mv_y_in), .ad_in(ad_in),
    .done(done), .sad_min(sad_min), .mv_x_best(mv_x_best), .mv_y_best(mv_y_best),
    .cand_cnt(cand_cnt), .seq_err(seq_err), .state_dbg(state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: {done cycle, sad, mv_x, mv_y, cnt}, and expected seq_err cycles
  logic [EXP_W-1:0] exp_q[$];
  int               err_q[$];
  logic [EXP_W-1:0] e;

  task automatic push_exp(input int c, input int sad, input int mx, input int my, input int cnt);
    exp_q.push_back({32'(c), SW'(sad), MV_W'(mx), MV_W'(my), CNT_W'(cnt)});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done || (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) <= cyc)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          if (!done) begin
            check("done_missing", done, 1);
          end else begin
            check("done_cycle", cyc, e[EXP_W-1 -: 32]);
            check("sad_min", sad_min, e[SW+2*MV_W+CNT_W-1 -: SW]);
            check("mv_x_best", mv_x_best, e[2*MV_W+CNT_W-1 -: MV_W]);
            check("mv_y_best", mv_y_best, e[MV_W+CNT_W-1 -: MV_W]);
            check("cand_cnt", cand_cnt, e[CNT_W-1:0]);
          end
        end
      end
      if (seq_err || (err_q.size() > 0 && err_q[0] <= cyc)) begin
        if (err_q.size() == 0) begin
          check("unexpected_seq_err", seq_err, 0);
        end else if (!seq_err) begin
          void'(err_q.pop_front());
          check("seq_err_missing", seq_err, 1);
        end else begin
          check("seq_err_cycle", cyc, err_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  function automatic logic [NPE*8-1:0] fill_ad(input int b);
    logic [NPE*8-1:0] r;
    for (int i = 0; i < NPE; i++) r[8*i +: 8] = 8'(b);
    return r;
  endfunction

  task automatic drive(input bit v, input bit f, input bit l, input int mx, input int my,
                       input logic [NPE*8-1:0] ad);
    @(posedge clk);
    #1;
    cand_valid = v;
    cand_first = f;
    cand_last  = l;
    mv_x_in    = MV_W'(mx);
    mv_y_in    = MV_W'(my);
    ad_in      = ad;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, fill_ad(200));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_seq_err"}, seq_err, 0);
    check({tag, "_sad_min"}, sad_min, 16'hFFFF);
    check({tag, "_mv_x"}, mv_x_best, 0);
    check({tag, "_mv_y"}, mv_y_best, 0);
    check({tag, "_cnt"}, cand_cnt, 0);
    check({tag, "_state"}, state_dbg, IDLE);
  endtask

  // stimulus table
  typedef struct {
    bit valid, first, last;
    int mvx, mvy, fill;
    bit exp_done, exp_err;
    int exp_sad, exp_mvx, exp_mvy, exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit v, bit f, bit l, int mx, int my, int fill,
                              bit ed, bit ee, int es, int emx, int emy, int ec);
    vec_t r;
    r.valid = v; r.first = f; r.last = l; r.mvx = mx; r.mvy = my; r.fill = fill;
    r.exp_done = ed; r.exp_err = ee;
    r.exp_sad = es; r.exp_mvx = emx; r.exp_mvy = emy; r.exp_cnt = ec;
    return r;
  endfunction

  localparam int NRND = 6;
  logic [NPE*8-1:0] rnd_ad [NRND];
  int rnd_sad [NRND];
  int rnd_mx [NRND];
  int rnd_my [NRND];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int best, rmin;
    rst = 1'b1;
    cand_valid = 0; cand_first = 0; cand_last = 0;
    mv_x_in = '0; mv_y_in = '0; ad_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // single candidate, max-byte candidate
    vecs.push_back(mk(1,1,1, 3,-2,  1, 1,0,   256, 3,-2,1));
    vecs.push_back(mk(1,1,1, 2, 2,255, 1,0, 65280, 2, 2,1));
    vecs.push_back(mk(0,0,0, 0, 0,  0, 0,0, 0,0,0,0));
    // 4-candidate search with a tie
    vecs.push_back(mk(1,1,0, 0,0, 10, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,0, 1,0,  4, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,0, 2,0,  4, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,1, 3,0,255, 1,0, 1024,1,0,4));
    // same search with bubbles, tags asserted on bubbles
    vecs.push_back(mk(1,1,0, 0,0, 10, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 7,7,  1, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,0, 1,0,  4, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,1, 9,9,  0, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,0, 2,0,  4, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,0, 8,8,  0, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,1, 3,0,255, 1,0, 1024,1,0,4));
    vecs.push_back(mk(0,0,0, 0,0,  0, 0,0, 0,0,0,0));
    // framing: no first while idle, then a restart mid-search
    vecs.push_back(mk(1,0,0, 5,5,  3, 0,1, 0,0,0,0));
    vecs.push_back(mk(1,0,1, 6,6,  3, 0,1, 0,0,0,0));
    vecs.push_back(mk(1,1,0, 1,1,  5, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,0, 2,2,  2, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,1,0, 4,4,  7, 0,1, 0,0,0,0));
    vecs.push_back(mk(1,0,1, 5,5,  6, 1,0, 1536,5,5,2));
    // first+last arriving inside a search
    vecs.push_back(mk(1,1,0, 0,0,  4, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,1,1, 1,2,  9, 1,1, 2304,1,2,1));
    // back-to-back searches, extreme MVs, zero SAD, tie across search end
    vecs.push_back(mk(1,1,0, 0, 1, 2, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,1, 6,-6, 1, 1,0, 256,6,-6,2));
    vecs.push_back(mk(1,1,1,63,-64,0, 1,0, 0,63,-64,1));
    vecs.push_back(mk(1,1,0,-1,-1, 3, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,1,-64,63,3, 1,0, 768,-1,-1,2));

    foreach (vecs[k]) begin
      drive(vecs[k].valid, vecs[k].first, vecs[k].last, vecs[k].mvx, vecs[k].mvy,
            fill_ad(vecs[k].fill));
      if (vecs[k].exp_done)
        push_exp(cyc + 3, vecs[k].exp_sad, vecs[k].exp_mvx, vecs[k].exp_mvy, vecs[k].exp_cnt);
      if (vecs[k].exp_err) err_q.push_back(cyc + 3);
    end
    idle(5);

    // random per-PE bytes; candidate 4 repeats candidate 1 to force a tie
    for (int k = 0; k < NRND; k++) begin
      rnd_sad[k] = 0;
      for (int i = 0; i < NPE; i++) begin
        rnd_ad[k][8*i +: 8] = 8'($urandom_range(0, 255));
        rnd_sad[k] += int'(rnd_ad[k][8*i +: 8]);
      end
      rnd_mx[k] = int'($urandom_range(0, 127)) - 64;
      rnd_my[k] = int'($urandom_range(0, 127)) - 64;
    end
    rnd_ad[4] = rnd_ad[1];
    rnd_sad[4] = rnd_sad[1];
    best = 0;
    rmin = rnd_sad[0];
    for (int k = 1; k < NRND; k++) begin
      if (rnd_sad[k] < rmin) begin
        rmin = rnd_sad[k];
        best = k;
      end
    end
    for (int k = 0; k < NRND; k++) begin
      drive(1, k == 0, k == NRND - 1, rnd_mx[k], rnd_my[k], rnd_ad[k]);
    end
    push_exp(cyc + 3, rmin, rnd_mx[best], rnd_my[best], NRND);
    idle(5);

    // reset mid-search: no done, outputs return to reset values
    drive(1, 1, 0, 2, 2, fill_ad(1));
    drive(1, 0, 0, 3, 3, fill_ad(1));
    idle(2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cand_valid = 0;
    #2;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
    check_reset_outputs("postrst");
    drive(1, 0, 0, 1, 1, fill_ad(5));
    err_q.push_back(cyc + 3);
    drive(1, 1, 0, 1, -1, fill_ad(4));
    drive(1, 0, 1, -2, 2, fill_ad(2));
    push_exp(cyc + 3, 512, -2, 2, 2);
    idle(5);

    // counter saturation over a 4100-candidate search
    drive(1, 1, 0, 1, 1, fill_ad(2));
    repeat (4098) drive(1, 0, 0, 0, 0, fill_ad(3));
    drive(1, 0, 1, -3, 4, fill_ad(1));
    push_exp(cyc + 3, 256, -3, 4, 4095);
    idle(6);

    // final report
    check("exp_q_drained", exp_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
